// File: rtl/vivepass_input_cond_if.sv
// Button-side and event-side signals of the VivePass input conditioner.
// The slave modport is the conditioner; the master modport is its environment.
interface vivepass_input_cond_if;
  logic btn_d;
  logic btn_st;
  logic D;
  logic ST;
  logic d_held;
  logic st_held;

  modport master (
    output btn_d, btn_st,
    input  D, ST, d_held, st_held
  );

  modport slave (
    input  btn_d, btn_st,
    output D, ST, d_held, st_held
  );
endinterface

// File: rtl/vivepass_input_cond.sv
// Synchronises and debounces the digit and submit buttons and emits single-cycle
// D / ST event pulses, never both in the same cycle.
module vivepass_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                  clk,
  input logic                  reset,
  vivepass_input_cond_if.slave bus
);

  typedef enum logic [2:0] {
    StLockout,
    StIdle,
    StArmPress,
    StHeld,
    StArmRelease
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Channel index 0 is the digit key, 1 is the submit key.
  logic [1:0]       raw, sync1_q, s_q;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       press, held;
  logic             d_q, d_d, st_q, st_d, pend_q, pend_d, d_evt;

  assign raw = {bus.btn_st, bus.btn_d};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CntMax) ? c : c + CntOne;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StLockout;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press[i]   = 1'b0;
      held[i]    = 1'b0;
      unique case (state_q[i])
        // A button held through reset must be seen released before it can arm.
        StLockout: begin
          if (s_q[i]) begin
            cnt_d[i] = '0;
          end else if (sat_inc(cnt_q[i]) == CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        StIdle: begin
          if (s_q[i]) begin
            state_d[i] = StArmPress;
            cnt_d[i]   = CntOne;
          end
        end
        StArmPress: begin
          if (!s_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (sat_inc(cnt_q[i]) == CntMax) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
            press[i]   = 1'b1;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        StHeld: begin
          held[i] = 1'b1;
          if (!s_q[i]) begin
            state_d[i] = StArmRelease;
            cnt_d[i]   = CntOne;
          end
        end
        StArmRelease: begin
          held[i] = 1'b1;
          if (s_q[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (sat_inc(cnt_q[i]) == CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = StLockout;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Submit wins a same-cycle collision; the digit event is deferred one cycle.
  always_comb begin
    d_evt  = press[0] | pend_q;
    st_d   = press[1];
    d_d    = d_evt & ~press[1];
    pend_d = d_evt & press[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q    <= 1'b0;
      st_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      st_q   <= st_d;
      pend_q <= pend_d;
    end
  end

  assign bus.D       = d_q;
  assign bus.ST      = st_q;
  assign bus.d_held  = held[0];
  assign bus.st_held = held[1];

endmodule

// File: tb/tb_vivepass_input_cond.sv
// Directed bench for vivepass_input_cond with DEBOUNCE_CYCLES = 4.
module tb_vivepass_input_cond;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  vivepass_input_cond_if bus ();

  vivepass_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {D, ST, d_held, st_held}.
  typedef struct {
    logic       bd;
    logic       bst;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   seen;

  function automatic void add(input int n, input logic bd, input logic bst,
                              input logic [3:0] exp);
    vec_t v;
    v.bd  = bd;
    v.bst = bst;
    v.exp = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  function automatic logic [3:0] outs();
    return {bus.D, bus.ST, bus.d_held, bus.st_held};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Clean press, hold, release.
    add(5, 1, 0, 4'b0000); add(1, 1, 0, 4'b1010); add(4, 1, 0, 4'b0010);
    add(5, 0, 0, 4'b0010); add(1, 0, 0, 4'b0000);
    // Bounce 1,0,1,1,0 then stable high.
    add(1, 1, 0, 4'b0000); add(1, 0, 0, 4'b0000); add(2, 1, 0, 4'b0000);
    add(1, 0, 0, 4'b0000); add(5, 1, 0, 4'b0000); add(1, 1, 0, 4'b1010);
    add(2, 1, 0, 4'b0010);
    // Two-cycle release glitch while held, then a real release.
    add(2, 0, 0, 4'b0010); add(6, 1, 0, 4'b0010); add(5, 0, 0, 4'b0010);
    add(2, 0, 0, 4'b0000);
    // Simultaneous press: ST first, D one cycle later.
    add(5, 1, 1, 4'b0000); add(1, 1, 1, 4'b0111); add(1, 1, 1, 4'b1011);
    add(1, 1, 1, 4'b0011); add(5, 0, 0, 4'b0011); add(1, 0, 0, 4'b0000);

    bus.btn_d  = 1'b0;
    bus.btn_st = 1'b0;
    reset      = 1'b0;
    #1;
    chk("reset_immediate", outs(), 4'b0000);
    step();
    step();
    chk("reset_held", outs(), 4'b0000);
    reset = 1'b1;
    repeat (2 * N + 2) step();
    chk("after_lockout", outs(), 4'b0000);

    foreach (vecs[i]) begin
      bus.btn_d  = vecs[i].bd;
      bus.btn_st = vecs[i].bst;
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Submit held through a reset pulse must not produce an event.
    bus.btn_st = 1'b1;
    repeat (8) step();
    reset = 1'b0;
    #1;
    chk("reset_async_clear", outs(), 4'b0000);
    step();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.ST || bus.st_held) seen++;
    end
    chk("held_through_reset_no_st", seen, 0);
    bus.btn_st = 1'b0;
    repeat (3 * N) step();
    bus.btn_st = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.ST) seen++;
    end
    chk("repress_one_st", seen, 1);
    bus.btn_st = 1'b0;
    repeat (3 * N) step();

    // Reset while the digit channel is arming.
    bus.btn_d = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("reset_mid_arm", outs(), 4'b0000);
    step();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.D) seen++;
    end
    chk("no_d_after_arm_reset", seen, 0);
    bus.btn_d = 1'b0;
    repeat (3 * N) step();

    // Reset while a digit event is pending behind ST.
    bus.btn_d  = 1'b1;
    bus.btn_st = 1'b1;
    repeat (N + 2) step();
    chk("pending_setup", outs(), 4'b0111);
    reset = 1'b0;
    #1;
    chk("reset_with_pending", outs(), 4'b0000);
    bus.btn_d  = 1'b0;
    bus.btn_st = 1'b0;
    step();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.D || bus.ST) seen++;
    end
    chk("pending_discarded", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
